// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for a 5-stage, 16-bit ISA pipeline.
// Ports:
//   clk, reset (async, active-high)
//   id_valid, id_instr      instruction currently in ID
//   ex_branch_taken         branch in EX resolved taken
//   mem_busy                data memory stall, freezes the whole pipeline
//   pc_en, ifid_en          PC / IF-ID load enables (combinational)
//   ifid_flush, idex_bubble NOP insertion controls (combinational)
//   fwd_a, fwd_b            registered EX operand source selects
//   halted                  pipeline drained after HALT
//   stall_count             saturating load-use stall counter
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [15:0]      id_instr,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [1:0] {RUN, DRAIN, HALT_ST} state_t;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [2:0] rd;
        logic       is_load;
    } slot_t;

    typedef struct packed {
        logic       use_a;
        logic [2:0] a;
        logic       use_b;
        logic [2:0] b;
        logic       wr;
        logic [2:0] rd;
        logic       is_load;
        logic       is_halt;
    } dec_t;

    state_t          state, state_nx;
    logic [DW-1:0]   cnt, cnt_nx;
    slot_t           s1, s2, s3;
    dec_t            dec;
    logic            load_use;
    logic            issue;
    logic            count_stall;

    logic [2:0] opc, f_rn, f_rd, f_rm;
    logic [1:0] f_op;
    assign opc  = id_instr[15:13];
    assign f_op = id_instr[12:11];
    assign f_rn = id_instr[10:8];
    assign f_rd = id_instr[7:5];
    assign f_rm = id_instr[2:0];

    // bits [4:3] carry no register information in this ISA
    logic unused_bits;
    assign unused_bits = ^id_instr[4:3];

    // Register read/write decode of the ID instruction
    always_comb begin
        dec = '0;
        case (opc)
            3'b110: begin
                if (f_op == 2'b10) begin
                    dec.wr = 1'b1; dec.rd = f_rn;
                end else if (f_op == 2'b00) begin
                    dec.use_b = 1'b1; dec.b = f_rm; dec.wr = 1'b1; dec.rd = f_rd;
                end
            end
            3'b101: begin
                dec.use_b = 1'b1; dec.b = f_rm;
                dec.use_a = (f_op != 2'b11); dec.a = f_rn;
                dec.wr    = (f_op != 2'b01); dec.rd = f_rd;
            end
            3'b011: begin
                if (f_op == 2'b00) begin
                    dec.use_a = 1'b1; dec.a = f_rn; dec.wr = 1'b1; dec.rd = f_rd;
                    dec.is_load = 1'b1;
                end
            end
            3'b100: begin
                if (f_op == 2'b00) begin
                    dec.use_a = 1'b1; dec.a = f_rn; dec.use_b = 1'b1; dec.b = f_rd;
                end
            end
            3'b010: begin
                if (f_op == 2'b11) begin
                    dec.wr = 1'b1; dec.rd = 3'd7;
                end else if (f_op == 2'b00) begin
                    dec.use_a = 1'b1; dec.a = f_rd;
                end else if (f_op == 2'b10) begin
                    dec.use_a = 1'b1; dec.a = f_rd; dec.wr = 1'b1; dec.rd = 3'd7;
                end
            end
            3'b111:  dec.is_halt = 1'b1;
            default: dec = '0;
        endcase
    end

    // Youngest writer wins; a load in EX is never forwarded (stall covers it)
    function automatic logic [1:0] fwd_sel(input logic use_s, input logic [2:0] s,
                                           input slot_t e, input slot_t m);
        if (use_s && e.valid && e.wr && !e.is_load && e.rd == s) return 2'b01;
        if (use_s && m.valid && m.wr && m.rd == s)               return 2'b10;
        return 2'b00;
    endfunction

    assign load_use = id_valid && s1.valid && s1.is_load && s1.wr &&
                      ((dec.use_a && s1.rd == dec.a) || (dec.use_b && s1.rd == dec.b));

    // Next state and pipeline control
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        issue       = 1'b0;
        count_stall = 1'b0;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                    end else if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        count_stall = 1'b1;
                    end else begin
                        issue = id_valid;
                        if (id_valid && dec.is_halt) begin
                            state_nx = DRAIN;
                            cnt_nx   = DW'(DRAIN_CYCLES);
                        end
                    end
                end
                DRAIN: begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    if (!mem_busy) begin
                        idex_bubble = 1'b1;
                        if (cnt <= DW'(1)) begin
                            state_nx = HALT_ST;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt - DW'(1);
                        end
                    end
                end
                default: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    // State, tracker, forwarding and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            halted      <= 1'b0;
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            fwd_a       <= 2'b00;
            fwd_b       <= 2'b00;
            stall_count <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            halted <= (state_nx == HALT_ST);
            if (!mem_busy) begin
                s3 <= s2;
                s2 <= s1;
                s1 <= issue ? slot_t'{valid: 1'b1, wr: dec.wr, rd: dec.rd, is_load: dec.is_load}
                            : slot_t'('0);
                fwd_a <= issue ? fwd_sel(dec.use_a, dec.a, s1, s2) : 2'b00;
                fwd_b <= issue ? fwd_sel(dec.use_b, dec.b, s1, s2) : 2'b00;
            end
            if (count_stall && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a stage-list reference model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [15:0] id_instr;
    logic        ex_branch_taken;
    logic        mem_busy;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: index 0=EX, 1=MEM, 2=WB; dst=-1 means no write
    bit m_v[3];
    int m_dst[3];
    bit m_ld[3];
    int m_hs;        // 0 run, 1 drain, 2 halted
    int m_left;
    int m_cnt;
    int m_fa, m_fb;
    bit prev_ifid, prev_fl, prev_br, prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void mdec(input logic [15:0] w, output int sa, output int sb,
                                 output int dst, output bit ld, output bit hlt);
        int opc, op, rn, rd, rm;
        opc = int'(w[15:13]); op = int'(w[12:11]);
        rn = int'(w[10:8]); rd = int'(w[7:5]); rm = int'(w[2:0]);
        sa = -1; sb = -1; dst = -1; ld = 0; hlt = 0;
        if (opc == 6 && op == 2) dst = rn;
        else if (opc == 6 && op == 0) begin sb = rm; dst = rd; end
        else if (opc == 5) begin
            if (op != 3) sa = rn;
            sb = rm;
            if (op != 1) dst = rd;
        end
        else if (opc == 3 && op == 0) begin sa = rn; dst = rd; ld = 1; end
        else if (opc == 4 && op == 0) begin sa = rn; sb = rd; end
        else if (opc == 2) begin
            if (op == 0 || op == 2) sa = rd;
            if (op == 3 || op == 2) dst = 7;
        end
        else if (opc == 7) hlt = 1;
    endfunction

    function automatic int mfwd(input int s);
        if (s < 0) return 0;
        if (m_v[0] && m_dst[0] == s && !m_ld[0]) return 1;
        if (m_v[1] && m_dst[1] == s) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_dst[i] = -1; m_ld[i] = 0; end
        m_hs = 0; m_left = 0; m_cnt = 0; m_fa = 0; m_fb = 0;
        prev_ifid = 1; prev_fl = 0; prev_br = 0; prev_busy = 0;
    endtask

    // Called at posedge+1: drive, check at negedge, advance model, return at next posedge+1
    task automatic cycle(input bit v, input logic [15:0] ins, input bit br, input bit busy);
        int sa, sb, dst, nfa, nfb;
        bit ld, hlt, lu, issue;
        bit e_pc, e_ifid, e_fl, e_bub;
        id_valid = v; id_instr = ins; ex_branch_taken = br; mem_busy = busy;
        mdec(ins, sa, sb, dst, ld, hlt);
        lu = v && m_v[0] && m_ld[0] && m_dst[0] >= 0 && (m_dst[0] == sa || m_dst[0] == sb);
        if (m_hs == 2)      begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; end
        else if (busy)      begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; end
        else if (m_hs == 1) begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; end
        else if (br)        begin e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1; end
        else if (lu)        begin e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; end
        else                begin e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0; end
        @(negedge clk);
        chk("pc_en", pc_en, e_pc);
        chk("ifid_en", ifid_en, e_ifid);
        chk("ifid_flush", ifid_flush, e_fl);
        chk("idex_bubble", idex_bubble, e_bub);
        chk("fwd_a", fwd_a, m_fa);
        chk("fwd_b", fwd_b, m_fb);
        chk("halted", halted, (m_hs == 2));
        chk("stall_count", stall_count, m_cnt);
        prev_ifid = e_ifid; prev_fl = e_fl; prev_br = br; prev_busy = busy;
        if (!busy) begin
            issue = (m_hs == 0) && v && !br && !lu;
            nfa = issue ? mfwd(sa) : 0;
            nfb = issue ? mfwd(sb) : 0;
            m_fa = nfa; m_fb = nfb;
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_dst[i] = m_dst[i-1]; m_ld[i] = m_ld[i-1];
            end
            m_v[0] = issue; m_dst[0] = issue ? dst : -1; m_ld[0] = issue && ld;
            if (m_hs == 0 && v && !br && lu && m_cnt < 65535) m_cnt++;
            if (issue && hlt) begin m_hs = 1; m_left = 3; end
            else if (m_hs == 1) begin
                m_left--;
                if (m_left == 0) m_hs = 2;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc_en"}, pc_en, 0);
        chk({tag, "_ifid_en"}, ifid_en, 0);
        chk({tag, "_flush"}, ifid_flush, 1);
        chk({tag, "_bubble"}, idex_bubble, 1);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_stall_count"}, stall_count, 0);
        chk({tag, "_fwd_a"}, fwd_a, 0);
        chk({tag, "_fwd_b"}, fwd_b, 0);
    endtask

    initial begin
        logic [15:0] r;
        bit v, br, busy;
        reset = 1; id_valid = 0; id_instr = '0; ex_branch_taken = 0; mem_busy = 0;
        model_reset();
        #1;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        reset = 0;

        // load-use: LDR R1,[R0] then ADD R2,R1,R3
        cycle(1, 16'h6020, 0, 0);
        cycle(1, 16'hA143, 0, 0);
        chk("lu_stall_count", stall_count, 1);
        cycle(1, 16'hA143, 0, 0);
        chk("lu_fwd_a", fwd_a, 2);
        chk("lu_fwd_b", fwd_b, 0);

        // EX forwarding: MOV R3,#5 then ADD R4,R3,R3
        cycle(1, 16'hD305, 0, 0);
        cycle(1, 16'hA383, 0, 0);
        chk("ex_fwd_a", fwd_a, 1);
        chk("ex_fwd_b", fwd_b, 1);

        // branch flush overriding a pending load-use stall
        cycle(1, 16'h6020, 0, 0);
        cycle(1, 16'hA143, 1, 0);
        chk("br_stall_count", stall_count, 1);
        cycle(0, 16'h0000, 0, 0);

        // CMP does not write, so no forwarding
        cycle(1, 16'hA902, 0, 0);
        cycle(1, 16'hA143, 0, 0);
        chk("cmp_fwd_a", fwd_a, 0);
        cycle(0, 16'h0000, 0, 0);

        // randomized traffic in RUN (HALT opcodes masked out)
        v = 0; r = '0; br = 0;
        for (int n = 0; n < 400; n++) begin
            if (prev_fl) begin
                v = 0; r = 16'($urandom);
            end else if (prev_ifid) begin
                v = ($urandom_range(0, 4) != 0);
                r = 16'($urandom);
                if ($urandom_range(0, 1) == 0) r[12:11] = 2'b00;
            end
            if (r[15:13] == 3'b111) r[15:13] = 3'b000;
            if (!(prev_busy && prev_br)) br = ($urandom_range(0, 7) == 0);
            busy = ($urandom_range(0, 5) == 0);
            cycle(v, r, br, busy);
        end

        // HALT drain with a two-cycle mem_busy pulse
        cycle(0, 16'h0000, 0, 0);
        cycle(0, 16'h0000, 0, 0);
        cycle(1, 16'hE000, 0, 0);
        cycle(0, 16'h0000, 0, 0);
        cycle(0, 16'h0000, 0, 1);
        cycle(0, 16'h0000, 0, 1);
        cycle(0, 16'h0000, 0, 0);
        chk("halt_not_yet", halted, 0);
        cycle(0, 16'h0000, 0, 0);
        chk("halt_done", halted, 1);
        for (int n = 0; n < 6; n++)
            cycle(1'($urandom), 16'($urandom), 0, 1'($urandom));

        // reset out of HALTED, then reset again in the middle of DRAIN
        reset = 1;
        #1;
        check_reset_outputs("rst_halted");
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        cycle(1, 16'h6020, 0, 0);
        cycle(1, 16'hA143, 0, 0);
        cycle(1, 16'hE000, 0, 0);
        cycle(0, 16'h0000, 0, 0);
        #2;
        reset = 1;
        #1;
        check_reset_outputs("rst_drain");
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        cycle(0, 16'h0000, 0, 0);
        chk("post_rst_halted", halted, 0);
        cycle(1, 16'hD305, 0, 0);
        cycle(1, 16'hA383, 0, 0);
        cycle(0, 16'h0000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
